// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: bundle between the EX stage and the iterative MUL/DIV
// sequencer.
//   master : EX-stage side. Drives the request, flush, result_ready and the
//            shared ALU's result/carry. Receives the handshake, result and
//            ALU operand/control overrides.
//   slave  : the sequencer.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            flush;
    logic            start_ready;
    logic            busy;
    logic            alu_sel;
    logic [3:0]      seq_alu_control;
    logic [XLEN-1:0] seq_aluin1;
    logic [XLEN-1:0] seq_aluin2;
    logic [XLEN-1:0] alu_result;
    logic            alu_sub_carryout;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            result_ready;

    modport master (
        output start, op, opa, opb, flush, result_ready, alu_result, alu_sub_carryout,
        input  start_ready, busy, alu_sel, seq_alu_control, seq_aluin1, seq_aluin2,
               result, result_valid
    );

    modport slave (
        input  start, op, opa, opb, flush, result_ready, alu_result, alu_sub_carryout,
        output start_ready, busy, alu_sel, seq_alu_control, seq_aluin1, seq_aluin2,
               result, result_valid
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative unsigned MUL (low half), DIVU and REMU.
// The block borrows the shared EX-stage ALU for one add or subtract per cycle.
// It does this for XLEN cycles and then presents the result over a
// valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request (start/op/opa/opb), flush, and stall (busy).
//                Also carries the ALU override (alu_sel, seq_*), the ALU
//                return (alu_result, alu_sub_carryout) and the result
//                handshake.
module alu_muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic              clk,
    input logic              rst_n,
    alu_muldiv_seq_if.slave  bus
);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Shared datapath registers:
    //   a: acc (MUL) / partial remainder (DIV/REM)
    //   b: mcand (MUL) / dividend shifting into quotient (DIV/REM)
    //   c: mplier (MUL) / divisor (DIV/REM)
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;

    logic [XLEN-1:0]   rem_sh;
    logic              ge;
    logic              is_mul;

    always_comb begin
        rem_sh = {a_q[XLEN-2:0], b_q[XLEN-1]};
        // The bit shifted out of rem makes the shifted value >= any divisor.
        ge     = a_q[XLEN-1] | bus.alu_sub_carryout;
        is_mul = (op_q == OP_MUL);
    end

    // Outputs depend only on registered state.
    always_comb begin
        bus.start_ready     = (state_q == S_IDLE);
        bus.busy            = (state_q == S_BUSY);
        bus.alu_sel         = (state_q == S_BUSY);
        bus.result_valid    = (state_q == S_DONE);
        // The quotient lives in b and everything else in a. Both registers
        // stay frozen outside BUSY, so result holds until the next accept.
        bus.result          = (op_q == OP_DIVU) ? b_q : a_q;
        bus.seq_alu_control = 4'b0000;
        bus.seq_aluin1      = '0;
        bus.seq_aluin2      = '0;
        if (state_q == S_BUSY) begin
            if (is_mul) begin
                bus.seq_alu_control = ALU_ADD;
                bus.seq_aluin1      = a_q;
                bus.seq_aluin2      = c_q[0] ? b_q : '0;
            end else begin
                bus.seq_alu_control = ALU_SUB;
                bus.seq_aluin1      = rem_sh;
                bus.seq_aluin2      = c_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && bus.op != OP_RSVD) begin
                        op_d  = bus.op;
                        cnt_d = '0;
                        c_d   = bus.opb;
                        if (bus.op != OP_MUL && bus.opb == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            a_d     = bus.opa;
                            b_d     = '1;
                            state_d = S_DONE;
                        end else begin
                            a_d     = '0;
                            b_d     = bus.opa;
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_mul) begin
                        a_d = bus.alu_result;
                        b_d = b_q << 1;
                        c_d = c_q >> 1;
                    end else begin
                        a_d = ge ? bus.alu_result : rem_sh;
                        b_d = {b_q[XLEN-2:0], ge};
                    end
                    if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
                end
                S_DONE: begin
                    if (bus.result_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed bench for alu_muldiv_seq.
// A behavioural combinational ALU closes the loop. Expected results go into
// a scoreboard queue at issue time and are popped when result_valid appears.
module tb_alu_muldiv_seq;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] sb[$];

    alu_muldiv_seq_if #(.XLEN(64)) bus ();

    alu_muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared EX-stage ALU model.
    always_comb begin
        bus.alu_result       = '0;
        bus.alu_sub_carryout = (bus.seq_aluin1 >= bus.seq_aluin2);
        case (bus.seq_alu_control)
            4'b0010: bus.alu_result = bus.seq_aluin1 + bus.seq_aluin2;
            4'b0110: bus.alu_result = bus.seq_aluin1 - bus.seq_aluin2;
            default: bus.alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for its result.
    // bp > 0 holds result_ready low for bp DONE cycles while start is poked.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                          input int bp);
        int lat;
        logic [63:0] e;
        @(negedge clk);
        bus.result_ready = (bp == 0);
        bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
        sb.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        if (exp_lat > 1) begin
            chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
            chk({tag, "_ctrl"}, {60'd0, bus.seq_alu_control}, (o == 2'b00) ? 64'd2 : 64'd6);
        end
        lat = 1;
        while (!bus.result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, {63'd0, bus.result_valid}, 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, bus.result, e);
        for (int i = 0; i < bp; i++) begin
            bus.start = 1'b1; bus.op = 2'b00; bus.opa = 64'd9; bus.opb = 64'd9;
            @(negedge clk);
            chk({tag, "_bp_valid"}, {63'd0, bus.result_valid}, 64'd1);
            chk({tag, "_bp_res"}, bus.result, e);
        end
        bus.start = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle"}, {63'd0, bus.start_ready}, 64'd1);
        chk({tag, "_noq_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.opa = '0; bus.opb = '0;
        bus.flush = 1'b0; bus.result_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_start_ready", {63'd0, bus.start_ready}, 64'd1);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_alu_sel", {63'd0, bus.alu_sel}, 64'd0);
        chk("rst_valid", {63'd0, bus.result_valid}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_ctrl", {60'd0, bus.seq_alu_control}, 64'd0);

        // Reserved op is ignored
        bus.start = 1'b1; bus.op = 2'b11; bus.opa = 64'd3; bus.opb = 64'd4;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rsvd_ready", {63'd0, bus.start_ready}, 64'd1);
        chk("rsvd_busy", {63'd0, bus.busy}, 64'd0);

        // Asynchronous reset in the middle of a MUL (iteration 30)
        bus.start = 1'b1; bus.op = 2'b00; bus.opa = 64'd7; bus.opb = 64'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {63'd0, bus.start_ready}, 64'd1);
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_valid", {63'd0, bus.result_valid}, 64'd0);
        chk("arst_result", bus.result, 64'd0);
        chk("arst_aluin1", bus.seq_aluin1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MUL
        run_op("mul_7x6", 2'b00, 64'd7, 64'd6, 64'd42, 65, 0);
        run_op("mul_ones", 2'b00, ONES, ONES, 64'd1, 65, 0);

        // DIVU / REMU
        run_op("divu_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op("remu_100_7", 2'b10, 64'd100, 64'd7, 64'd2, 65, 0);
        run_op("divu_ones_1", 2'b01, ONES, 64'd1, ONES, 65, 0);
        run_op("remu_ones_1", 2'b10, ONES, 64'd1, 64'd0, 65, 0);
        run_op("divu_top", 2'b01, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'd1, 65, 0);
        run_op("remu_top", 2'b10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'd1, 65, 0);

        // Divide by zero short-circuit
        run_op("divu_by0", 2'b01, 64'd5, 64'd0, ONES, 1, 0);
        run_op("remu_by0", 2'b10, 64'd5, 64'd0, 64'd5, 1, 0);

        // Backpressure: ready low for 10 DONE cycles, start poked meanwhile
        run_op("bp_divu", 2'b01, 64'd100, 64'd7, 64'd14, 65, 10);

        // Flush at iteration 20 of a DIVU
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.opa = 64'd1000; bus.opb = 64'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_idle", {63'd0, bus.start_ready}, 64'd1);
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        vcount = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.result_valid) vcount++;
        end
        chk("flush_no_valid", 64'(vcount), 64'd0);

        run_op("mul_3x5", 2'b00, 64'd3, 64'd5, 64'd15, 65, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative controller that implements 64-bit unsigned MUL (low half), DIVU and REMU. It does so by sequencing the existing shared EX-stage ALU one add or subtract per cycle, so no dedicated multiplier or divider is needed. It sits beside the ALU in the EX stage. While busy it takes over the ALU operand/control mux and stalls the pipeline. It returns the result over a valid/ready handshake.

Parameters:
XLEN, 64, operand/result width; must match ALU width
CNT_W, 7, iteration counter width; must hold XLEN

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when start_ready=1
op  input  2  00=MUL (low XLEN bits), 01=DIVU (quotient), 10=REMU (remainder), 11=reserved
opa  input  XLEN  multiplicand / dividend, sampled on accept
opb  input  XLEN  multiplier / divisor, sampled on accept
flush  input  1  pipeline kill; aborts any operation
start_ready  output  1  high only in IDLE
busy  output  1  high in BUSY; drives pipeline stall
alu_sel  output  1  high in BUSY; EX mux routes the seq_* signals below into the ALU
seq_alu_control  output  4  4'b0010 (ADD) for MUL, 4'b0110 (SUB) for DIV/REM, 4'b0000 otherwise
seq_aluin1  output  XLEN  ALU operand 1
seq_aluin2  output  XLEN  ALU operand 2
alu_result  input  XLEN  ALU result
alu_sub_carryout  input  1  ALU subtract carry (1 = no borrow, in1 >= in2 unsigned)
result  output  XLEN  final value, stable while result_valid=1
result_valid  output  1  high in DONE
result_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and every internal register clears.
  - Outputs: start_ready=1; busy=0; alu_sel=0; result_valid=0; result=0; seq_* outputs=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - An accept is a cycle with start=1 and op!=11.
  - On accept: latch op, opa and opb; cnt=0; go to BUSY.
  - start with op=11 is ignored; the block stays in IDLE.
- MUL datapath:
  - Init: acc=0, mcand=opa, mplier=opb.
  - Each BUSY cycle:
    - seq_aluin1=acc.
    - seq_aluin2 = mplier[0] ? mcand : 0.
    - acc <= alu_result.
    - mcand <= mcand<<1.
    - mplier <= mplier>>1.
  - Overflow past XLEN bits is discarded.
- DIV/REM datapath (restoring, unsigned):
  - Init: rem=0, dvd=opa, dvs=opb.
  - Each BUSY cycle:
    - rem_sh = {rem[XLEN-2:0], dvd[XLEN-1]}; top = rem[XLEN-1].
    - seq_aluin1=rem_sh, seq_aluin2=dvs.
    - ge = top | alu_sub_carryout.
    - rem <= ge ? alu_result : rem_sh.
    - dvd <= {dvd[XLEN-2:0], ge}.
  - After the final iteration, dvd holds the quotient and rem holds the remainder.
- BUSY:
  - cnt increments each cycle.
  - When cnt==XLEN-1, that cycle's iteration completes and the state goes to DONE.
  - Latency: accept in cycle N gives result_valid=1 in cycle N+XLEN+1 (N+65 at default XLEN).
- Divide by zero (opb=0 with DIVU/REMU):
  - Short-circuit: at accept, go directly to DONE.
  - Result is quotient=all ones (DIVU) or remainder=opa (REMU), valid in cycle N+1.
- DONE:
  - result holds the value selected by op.
  - When result_valid && result_ready, go to IDLE; start_ready rises the next cycle.
  - result holds its value until the next accept.
- flush:
  - Has priority over every other event in any state.
  - Next state is IDLE, result_valid=0, and no result is produced.
  - start in the same cycle as flush is not accepted.
- start while BUSY or DONE: ignored; the block does not queue requests.
- The ALU is assumed combinational. The seq_* outputs are a pure function of registered state; there is no input-to-output combinational path.

Test Plan:
- Reset mid-BUSY (rst_n low at iteration 30) -> same cycle: start_ready=1, busy=0, result_valid=0, result=0.
- MUL: opa=7, opb=6, accepted at cycle 0 -> busy cycles 1-64, result_valid at cycle 65, result=42. Then opa=opb=0xFFFF_FFFF_FFFF_FFFF -> result=1.
- DIVU/REMU: opa=100, opb=7 -> quotient=14, remainder=2. opa=0xFFFF_FFFF_FFFF_FFFF, opb=1 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0. opa=0x8000_0000_0000_0001, opb=0x8000_0000_0000_0000 (exercises top bit) -> quotient=1, remainder=1.
- Divide by zero: DIVU opa=5, opb=0 -> result_valid one cycle after accept, result=0xFFFF_FFFF_FFFF_FFFF. REMU with the same operands -> result=5.
- Backpressure: result_ready held low for 10 cycles after DONE -> result_valid and result stay stable; start asserted during those cycles is ignored. Raising result_ready -> IDLE next cycle.
- flush at iteration 20 of a DIVU -> IDLE the next cycle, result_valid never asserts. A new MUL 3*5 then completes normally with result=15.
